// File: rtl/vga_fb_flip_ctrl_if.sv
// I/O register bus between the CPU side (master) and the page-flip controller (slave).
interface vga_fb_flip_ctrl_if;
   logic        io_write_en;
   logic        io_read_en;
   logic [31:0] io_address;
   logic [31:0] io_write_data;
   logic [31:0] io_read_data;

   modport master (
      output io_write_en,
      output io_read_en,
      output io_address,
      output io_write_data,
      input  io_read_data
   );

   modport slave (
      input  io_write_en,
      input  io_read_en,
      input  io_address,
      input  io_write_data,
      output io_read_data
   );
endinterface

// File: rtl/vga_fb_flip_ctrl.sv
// Framebuffer page-flip controller: queues a new scan-out base from software, pulses it to the
// scan-out DMA engine and retires the flip on the first frame start that uses the new base.
// Optional interrupt support is built only when VGA_FLIP_IRQ_EN is defined.
module vga_fb_flip_ctrl #(
   parameter logic [31:0] BASE_ADDRESS    = 32'hffff0100,
   parameter logic [31:0] DEFAULT_FB_ADDR = 32'h10000000
) (
   input  logic                     clk,
   input  logic                     reset,
   vga_fb_flip_ctrl_if.slave        io_bus,
   output logic                     fb_base_update_en,
   output logic [31:0]              fb_new_base,
   input  logic                     frame_toggle,
   output logic                     frame_irq
);

   localparam logic [31:0] OffsBase   = 32'h0;
   localparam logic [31:0] OffsStatus = 32'h4;
   localparam logic [31:0] OffsCtrl   = 32'h8;
   localparam logic [31:0] OffsAck    = 32'hc;

   logic [31:0] r_displayed_base;
   logic [31:0] r_pending_base;
   logic        r_flip_pending;
   logic [1:0]  r_pulse_age;
   logic        r_update_en;
   logic [31:0] r_new_base;
   logic        r_toggle_q;
   logic        r_toggle_vld;
   logic [15:0] r_frame_count;
   logic [31:0] r_read_data;

   logic        w_sel_base;
   logic        w_sel_status;
   logic        w_sel_ctrl;
   logic        w_sel_ack;
   logic        w_wr_base;
   logic        w_edge;
   logic        w_complete;
   logic        w_irq_status;
   logic        w_irq_enable;
   logic [31:0] w_rd_data;

   assign w_sel_base   = (io_bus.io_address == BASE_ADDRESS + OffsBase);
   assign w_sel_status = (io_bus.io_address == BASE_ADDRESS + OffsStatus);
   assign w_sel_ctrl   = (io_bus.io_address == BASE_ADDRESS + OffsCtrl);
   assign w_sel_ack    = (io_bus.io_address == BASE_ADDRESS + OffsAck);
   assign w_wr_base    = io_bus.io_write_en & w_sel_base;

   // The first sample after reset only seeds toggle_q, so it can never report an edge.
   assign w_edge = r_toggle_vld & (frame_toggle != r_toggle_q);

   // An edge one cycle after the pulse belongs to the frame that latched the old base; age 2
   // or more means the engine has already started a frame with the new base.
   assign w_complete = w_edge & r_flip_pending & (r_pulse_age == 2'd2);

   // Frame-start detection: sample the scan-out toggle every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_toggle_q   <= 1'b0;
         r_toggle_vld <= 1'b0;
      end else begin
         r_toggle_q   <= frame_toggle;
         r_toggle_vld <= 1'b1;
      end
   end

   // Free-running frame counter, wraps at 16 bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frame_count <= 16'h0000;
      end else if (w_edge) begin
         r_frame_count <= r_frame_count + 16'h0001;
      end
   end

   // Flip bookkeeping; a write in the completion cycle re-arms after the old flip retires.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_displayed_base <= DEFAULT_FB_ADDR;
         r_pending_base   <= DEFAULT_FB_ADDR;
         r_flip_pending   <= 1'b0;
      end else begin
         if (w_complete) begin
            r_displayed_base <= r_pending_base;
            r_flip_pending   <= 1'b0;
         end
         if (w_wr_base) begin
            r_pending_base <= io_bus.io_write_data;
            r_flip_pending <= 1'b1;
         end
      end
   end

   // Cycles since the last update pulse, saturating at 2 (pulse cycle reads 0).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pulse_age <= 2'd2;
      end else if (w_wr_base) begin
         r_pulse_age <= 2'd0;
      end else if (r_pulse_age != 2'd2) begin
         r_pulse_age <= r_pulse_age + 2'd1;
      end
   end

   // One-cycle update pulse to the scan-out engine with its qualified base.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_update_en <= 1'b0;
         r_new_base  <= DEFAULT_FB_ADDR;
      end else begin
         r_update_en <= w_wr_base;
         if (w_wr_base) begin
            r_new_base <= io_bus.io_write_data;
         end
      end
   end

   assign fb_base_update_en = r_update_en;
   assign fb_new_base       = r_new_base;

`ifdef VGA_FLIP_IRQ_EN
   logic r_irq_status;
   logic r_irq_enable;
   logic r_frame_irq;
   logic w_wr_ctrl;
   logic w_ack;

   assign w_wr_ctrl = io_bus.io_write_en & w_sel_ctrl;
   assign w_ack     = io_bus.io_write_en & w_sel_ack & io_bus.io_write_data[0];

   // Interrupt status/enable; a completion in the ack cycle keeps the status set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irq_status <= 1'b0;
         r_irq_enable <= 1'b0;
         r_frame_irq  <= 1'b0;
      end else begin
         if (w_complete) begin
            r_irq_status <= 1'b1;
         end else if (w_ack) begin
            r_irq_status <= 1'b0;
         end
         if (w_wr_ctrl) begin
            r_irq_enable <= io_bus.io_write_data[0];
         end
         r_frame_irq <= r_irq_status & r_irq_enable;
      end
   end

   assign w_irq_status = r_irq_status;
   assign w_irq_enable = r_irq_enable;
   assign frame_irq    = r_frame_irq;
`else
   assign w_irq_status = 1'b0;
   assign w_irq_enable = 1'b0;
   assign frame_irq    = 1'b0;
`endif

   // Register read mux; unmapped and write-only addresses return zero.
   always_comb begin
      w_rd_data = 32'h0;
      if (w_sel_base) begin
         w_rd_data = r_displayed_base;
      end else if (w_sel_status) begin
         w_rd_data = {r_frame_count, 14'h0, w_irq_status, r_flip_pending};
      end else if (w_sel_ctrl) begin
         w_rd_data = {31'h0, w_irq_enable};
      end
   end

   // Registered read data, held until the next read strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_read_data <= 32'h0;
      end else if (io_bus.io_read_en) begin
         r_read_data <= w_rd_data;
      end
   end

   assign io_bus.io_read_data = r_read_data;

endmodule

// File: tb/tb_vga_fb_flip_ctrl.sv
// Scoreboard bench for vga_fb_flip_ctrl: drivers push expected reads and update pulses, a
// monitor pops and compares whenever the DUT presents read data or an update pulse.
module tb_vga_fb_flip_ctrl;

   localparam logic [31:0] Base    = 32'hffff0100;
   localparam logic [31:0] ABase   = Base;
   localparam logic [31:0] AStatus = Base + 32'h4;
   localparam logic [31:0] ACtrl   = Base + 32'h8;
   localparam logic [31:0] AAck    = Base + 32'hc;
`ifdef VGA_FLIP_IRQ_EN
   localparam logic [31:0] SIrq = 32'h2;
`else
   localparam logic [31:0] SIrq = 32'h0;
`endif

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        frame_toggle = 1'b0;
   logic        fb_base_update_en;
   logic [31:0] fb_new_base;
   logic        frame_irq;

   int   n_checks = 0;
   int   n_fail = 0;
   int   pulse_cnt = 0;
   exp_t rd_q[$];
   exp_t pulse_q[$];

   vga_fb_flip_ctrl_if bus ();

   vga_fb_flip_ctrl dut (
      .clk               (clk),
      .reset             (reset),
      .io_bus            (bus),
      .fb_base_update_en (fb_base_update_en),
      .fb_new_base       (fb_new_base),
      .frame_toggle      (frame_toggle),
      .frame_irq         (frame_irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      @(posedge clk);
      #1;
      bus.io_write_en   = 1'b1;
      bus.io_address    = addr;
      bus.io_write_data = data;
      @(posedge clk);
      #1;
      bus.io_write_en = 1'b0;
   endtask

   task automatic wr_base(input logic [31:0] data);
      exp_t e;
      e.name = "pulse_base";
      e.val  = data;
      pulse_q.push_back(e);
      wr(ABase, data);
   endtask

   task automatic rd(input logic [31:0] addr, input string name, input logic [31:0] exp);
      exp_t e;
      @(posedge clk);
      #1;
      bus.io_read_en = 1'b1;
      bus.io_address = addr;
      e.name = name;
      e.val  = exp;
      rd_q.push_back(e);
      @(posedge clk);
      #1;
      bus.io_read_en = 1'b0;
   endtask

   task automatic tgl();
      frame_toggle = ~frame_toggle;
   endtask

   // Monitor: read data is presented the cycle after a strobe; pulses whenever update_en is high.
   initial begin
      logic rd_d;
      exp_t e;
      forever begin
         @(posedge clk);
         rd_d = bus.io_read_en;
         @(negedge clk);
         if (rd_d === 1'b1) begin
            if (rd_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL read_unexpected: got 0x%08h, expected no read", bus.io_read_data);
            end else begin
               e = rd_q.pop_front();
               check(e.name, bus.io_read_data, e.val);
            end
         end
         if (fb_base_update_en === 1'b1) begin
            pulse_cnt++;
            if (pulse_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL pulse_unexpected: got base 0x%08h, expected no pulse", fb_new_base);
            end else begin
               e = pulse_q.pop_front();
               check(e.name, fb_new_base, e.val);
            end
         end
      end
   end

   initial begin
      int p;
      bus.io_write_en   = 1'b0;
      bus.io_read_en    = 1'b0;
      bus.io_address    = 32'h0;
      bus.io_write_data = 32'h0;
      cyc(3);
      check("rst_read_data", bus.io_read_data, 32'h0);
      check("rst_update_en", {31'h0, fb_base_update_en}, 32'h0);
      check("rst_new_base", fb_new_base, 32'h10000000);
      check("rst_irq", {31'h0, frame_irq}, 32'h0);
      reset = 1'b0;
      cyc(2);

      // Reset values and idle behaviour.
      rd(ABase, "fb_base_reset", 32'h10000000);
      rd(AStatus, "status_reset", 32'h0);
      cyc(100);
      check("no_pulse_idle", pulse_cnt, 0);

      // Single flip, edge well after the pulse.
      wr_base(32'h10200000);
      rd(AStatus, "status_pending", 32'h00000001);
      cyc(2);
      tgl();
      cyc(2);
      rd(ABase, "fb_base_flip1", 32'h10200000);
      rd(AStatus, "status_flip1", 32'h00010000 | SIrq);
      check("pulses_flip1", pulse_cnt, 1);

      // Edge in pulse cycle + 1 belongs to the old base.
      wr_base(32'h10400000);
      cyc(1);
      tgl();
      cyc(2);
      rd(AStatus, "status_early_edge", 32'h00020001 | SIrq);
      rd(ABase, "fb_base_early_edge", 32'h10200000);
      tgl();
      cyc(2);
      rd(ABase, "fb_base_flip2", 32'h10400000);
      rd(AStatus, "status_flip2", 32'h00030000 | SIrq);

      // Back-to-back writes: only the last value goes live.
      wr_base(32'h10100000);
      wr_base(32'h10300000);
      rd(ABase, "fb_base_b2b_before", 32'h10400000);
      cyc(1);
      tgl();
      cyc(2);
      rd(ABase, "fb_base_b2b", 32'h10300000);
      rd(AStatus, "status_b2b", 32'h00040000 | SIrq);
      check("pulses_b2b", pulse_cnt, 4);

      // Write in the same cycle as a completing edge.
      wr_base(32'h10500000);
      cyc(2);
      @(posedge clk);
      #1;
      bus.io_write_en   = 1'b1;
      bus.io_address    = ABase;
      bus.io_write_data = 32'h10600000;
      pulse_q.push_back('{name: "pulse_base", val: 32'h10600000});
      tgl();
      @(posedge clk);
      #1;
      bus.io_write_en = 1'b0;
      cyc(1);
      rd(ABase, "fb_base_coinc", 32'h10500000);
      rd(AStatus, "status_coinc", 32'h00050001 | SIrq);
      tgl();
      cyc(2);
      rd(ABase, "fb_base_coinc_done", 32'h10600000);
      rd(AStatus, "status_coinc_done", 32'h00060000 | SIrq);

      // Unmapped / write-only addresses.
      p = pulse_cnt;
      wr(Base + 32'h10, 32'hdeadbeef);
      rd(Base + 32'h10, "rd_unmapped", 32'h0);
      rd(Base + 32'h2, "rd_misaligned", 32'h0);
      rd(AAck, "rd_irq_ack", 32'h0);
      rd(ABase, "fb_base_after_unmapped", 32'h10600000);
      check("no_pulse_unmapped", pulse_cnt - p, 0);

`ifdef VGA_FLIP_IRQ_EN
      wr(AAck, 32'h1);
      rd(AStatus, "status_acked", 32'h00060000);
      wr(ACtrl, 32'h1);
      rd(ACtrl, "ctrl_enabled", 32'h1);
      check("irq_idle", {31'h0, frame_irq}, 32'h0);
      wr_base(32'h10700000);
      cyc(2);
      tgl();
      cyc(1);
      check("irq_not_yet", {31'h0, frame_irq}, 32'h0);
      cyc(1);
      check("irq_set", {31'h0, frame_irq}, 32'h1);
      wr(AAck, 32'h1);
      check("irq_ack_latency", {31'h0, frame_irq}, 32'h1);
      cyc(1);
      check("irq_cleared", {31'h0, frame_irq}, 32'h0);
      wr_base(32'h10800000);
      cyc(2);
      @(posedge clk);
      #1;
      bus.io_write_en   = 1'b1;
      bus.io_address    = AAck;
      bus.io_write_data = 32'h1;
      tgl();
      @(posedge clk);
      #1;
      bus.io_write_en = 1'b0;
      cyc(2);
      check("irq_ack_vs_set", {31'h0, frame_irq}, 32'h1);
      rd(AStatus, "status_ack_vs_set", 32'h00080002);
`else
      wr(ACtrl, 32'h1);
      wr(AAck, 32'h1);
      rd(ACtrl, "ctrl_disabled", 32'h0);
      cyc(2);
      check("irq_tied_low", {31'h0, frame_irq}, 32'h0);
`endif

      // Reset in the middle of a pending flip, with frame_toggle moving during reset.
      wr_base(32'h10900000);
      cyc(1);
      reset = 1'b1;
      cyc(1);
      tgl();
      cyc(1);
      check("update_en_in_reset", {31'h0, fb_base_update_en}, 32'h0);
      reset = 1'b0;
      cyc(2);
      check("new_base_after_reset", fb_new_base, 32'h10000000);
      check("irq_after_reset", {31'h0, frame_irq}, 32'h0);
      rd(ABase, "fb_base_after_reset", 32'h10000000);
      rd(AStatus, "status_after_reset", 32'h0);
      rd(ACtrl, "ctrl_after_reset", 32'h0);

      // Frame counter wrap: 65537 edges, one per cycle.
      p = pulse_cnt;
      repeat (65537) begin
         tgl();
         cyc(1);
      end
      cyc(2);
      rd(AStatus, "status_wrap", 32'h00010000);
      rd(ABase, "fb_base_wrap", 32'h10000000);
      check("no_pulse_wrap", pulse_cnt - p, 0);

      cyc(3);
      check("rd_queue_empty", rd_q.size(), 0);
      check("pulse_queue_empty", pulse_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_fb_flip_ctrl.md
Name: vga_fb_flip_ctrl

Overview:
- Memory-mapped framebuffer page-flip controller sitting upstream of the VGA scan-out DMA engine on the I/O register bus.
- Accepts a new framebuffer base address from software and forwards it to the scan-out engine as a one-cycle update pulse.
- Tracks the scan-out engine's frame_toggle to determine the exact frame on which the new base went live.
- Exposes flip-pending status and a free-running frame counter; optionally raises an interrupt on flip completion for tear-free double buffering.

Parameters:
- BASE_ADDRESS, 32'hffff0100, I/O address of register 0; registers occupy BASE_ADDRESS+0x0 to +0xC.
- DEFAULT_FB_ADDR, 32'h10000000, displayed base after reset; must match the scan-out engine's reset base.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- io_write_en  in  1  register write strobe, single cycle
- io_read_en  in  1  register read strobe, single cycle
- io_address  in  32  register byte address
- io_write_data  in  32  write data
- io_read_data  out  32  read data, registered
- fb_base_update_en  out  1  one-cycle pulse to scan-out engine
- fb_new_base  out  32  base address qualified by fb_base_update_en
- frame_toggle  in  1  inverts once per frame start, from scan-out engine
- frame_irq  out  1  level interrupt, flip complete

Behaviour:
- Register map (offset):
  - 0x0 FB_BASE: write queues a flip; read returns displayed_base.
  - 0x4 STATUS (RO): [0]=flip_pending, [1]=irq_status, [31:16]=frame_count.
  - 0x8 CONTROL (RW): [0]=irq_enable; other bits read 0.
  - 0xC IRQ_ACK (WO): writing 1 to bit0 clears irq_status; reads 0.
  - Addresses outside the map: writes ignored, reads return 0.
- Reset values: displayed_base=DEFAULT_FB_ADDR, pending_base=DEFAULT_FB_ADDR, flip_pending=0, irq_status=0, irq_enable=0, frame_count=0, io_read_data=0, fb_base_update_en=0, fb_new_base=DEFAULT_FB_ADDR, frame_irq=0. The toggle_q sampling register loads frame_toggle's value on the first clock after reset deasserts; no edge is reported in that cycle.
- Read latency: io_read_data is valid on the cycle after io_read_en and holds until the next read.
- Flip issue:
  - A write to FB_BASE in cycle W sets pending_base=io_write_data and flip_pending=1.
  - fb_new_base=io_write_data and fb_base_update_en=1 in cycle W+1 only.
  - pulse_age restarts at 0 in cycle W+1.
- Toggle edge detect: edge = (frame_toggle != toggle_q); toggle_q is registered every cycle.
- Flip completion:
  - With the update pulse in cycle N, an edge seen in cycle N+1 belongs to the old base (the engine latched its base on the same clock edge as the pulse). It does not complete the flip.
  - The first edge seen in cycle N+2 or later completes the flip: displayed_base<=pending_base, flip_pending<=0, irq_status<=1.
- frame_count: 16-bit; increments on every detected edge regardless of flip state; wraps 0xffff->0x0000.
- Back-to-back writes: a FB_BASE write while flip_pending=1 overwrites pending_base, issues a new pulse, and restarts the N+2 window. Only the last value completes.
- Simultaneous events:
  - FB_BASE write in the same cycle as a completing edge: the edge completes the old pending flip and the write then re-arms. flip_pending stays 1, and displayed_base takes the old pending value.
  - IRQ_ACK in the same cycle as completion: the set wins and irq_status stays 1.
- frame_irq = irq_status & irq_enable, registered (asserts one cycle after the condition holds).
- Reset mid-flip: all state returns to reset values and no pulse is emitted. Software must rewrite FB_BASE, because the scan-out engine also resets to DEFAULT_FB_ADDR.

Optional Feature:
- Macro: VGA_FLIP_IRQ_EN.
- Defined: irq_status, CONTROL.irq_enable, IRQ_ACK and frame_irq behave as above.
- Not defined:
  - frame_irq is tied 0; STATUS[1] and CONTROL read 0; writes to 0x8/0xC are ignored.
  - No irq flops are synthesized.
  - All other behaviour is unchanged.

Test Plan:
- Reset, then read FB_BASE and STATUS -> 0x10000000 and 0x00000000; fb_base_update_en stays 0 for 100 cycles.
- Write 0x10200000 to FB_BASE, then toggle frame_toggle 5 cycles later -> one pulse with fb_new_base=0x10200000; STATUS[0]=1 until the edge, then FB_BASE reads 0x10200000, STATUS[0]=0, frame_count=1.
- Write FB_BASE, then toggle frame_toggle so the edge is seen exactly in pulse cycle+1 -> flip stays pending and frame_count=1. Next toggle -> completes, frame_count=2.
- Writes 0x10100000 then 0x10300000 two cycles apart, then one toggle -> two pulses; displayed base 0x10300000, never 0x10100000.
- (VGA_FLIP_IRQ_EN) CONTROL=1, then complete a flip -> frame_irq=1 one cycle after completion. IRQ_ACK=1 -> frame_irq=0. Ack coincident with a new completion -> frame_irq stays 1.
- Toggle frame_toggle 65537 times with no writes -> STATUS[31:16]=0x0001, STATUS[0]=0, no pulses.
